link_serializer: RTL and testbench

Physical-layer transmitter between the transport sender and the inter-board wire. It accepts the byte stream produced by `transportSend` (`sending` strobe plus 8-bit `packetOut`) and buffers it in a small FIFO. Each byte is serialized onto a single idle-high line as an asynchronous frame: start bit, 8 data bits LSB first, optional parity bit, stop bit. A matching deserializer feeds `transportRcv` on the far board.

---
 rtl/link_serializer.sv | 165 ++++++++++++++++
 tb/tb_link_serializer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/link_serializer.sv
// Async-frame serial transmitter with input FIFO: start, 8 data bits LSB first, stop.
// Define LINK_PARITY_EN to insert an even parity bit before the stop bit.
module link_serializer #(
  parameter int unsigned CLKS_PER_BIT    = 16,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sending,
  input  logic [7:0]               packetIn,
  output logic                     full,
  output logic                     overflow,
  output logic [FIFO_DEPTH_LOG2:0] fifoCount,
  output logic                     txOut,
  output logic                     txBusy
);

  localparam int unsigned Depth  = 2 ** FIFO_DEPTH_LOG2;
  localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PtrW   = FIFO_DEPTH_LOG2;
  localparam int unsigned CntW   = FIFO_DEPTH_LOG2 + 1;
  localparam logic [TimerW-1:0] BitLast   = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]   CountFull = CntW'(Depth);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef LINK_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e            r_state, w_state_next;
  logic [TimerW-1:0] r_timer;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic [7:0]        r_mem [Depth];
  logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]   r_count, w_count_next;
  logic              r_full, r_overflow;
  logic              w_bit_done, w_push, w_pop;
`ifdef LINK_PARITY_EN
  logic              r_parity;
`endif

  assign w_bit_done = (r_timer == BitLast);
  assign w_push     = sending & ~r_full;
  assign full       = r_full;
  assign overflow   = r_overflow;
  assign fifoCount  = r_count;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // FSM next state; the pop strobe is decided here so STOP can chain straight into START
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_state_next = StStart;
        end
      end
      StStart: if (w_bit_done) w_state_next = StData;
      StData: begin
        if (w_bit_done && (r_bit_cnt == 3'd7)) begin
`ifdef LINK_PARITY_EN
          w_state_next = StParity;
`else
          w_state_next = StStop;
`endif
        end
      end
`ifdef LINK_PARITY_EN
      StParity: if (w_bit_done) w_state_next = StStop;
`endif
      StStop: begin
        if (w_bit_done) begin
          if (r_count != '0) begin
            w_pop        = 1'b1;
            w_state_next = StStart;
          end else begin
            w_state_next = StIdle;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs; txOut is decoded from state so reset forces the line idle at once
  always_comb begin
    txOut = 1'b1;
    unique case (r_state)
      StStart:  txOut = 1'b0;
      StData:   txOut = r_shift[0];
`ifdef LINK_PARITY_EN
      StParity: txOut = r_parity;
`endif
      default:  txOut = 1'b1;
    endcase
    txBusy = (r_state != StIdle) || (r_count != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
`ifdef LINK_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      if (w_pop) begin
        r_shift  <= r_mem[r_rd_ptr];
`ifdef LINK_PARITY_EN
        r_parity <= ^r_mem[r_rd_ptr];
`endif
      end else if ((r_state == StData) && w_bit_done) begin
        r_shift <= r_shift >> 1;
      end
      if ((r_state == StIdle) || w_bit_done) r_timer <= '0;
      else                                   r_timer <= r_timer + TimerW'(1);
      if (r_state != StData)   r_bit_cnt <= '0;
      else if (w_bit_done)     r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= packetIn;
  end

  always_comb begin
    w_count_next = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CntW'(1);
      2'b01:   w_count_next = r_count - CntW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count    <= w_count_next;
      r_full     <= (w_count_next == CountFull);
      r_overflow <= r_overflow | (sending & r_full);
    end
  end

endmodule

// File: tb/tb_link_serializer.sv
// Scoreboard bench for link_serializer: bytes queued on strobe, checked as frames decode.
module tb_link_serializer;

  localparam int CPB   = 4;
  localparam int LOG2  = 4;
`ifdef LINK_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic            clk = 1'b0;
  logic            reset;
  logic            sending;
  logic [7:0]      packetIn;
  logic            full, overflow, txOut, txBusy;
  logic [LOG2:0]   fifoCount;

  link_serializer #(
    .CLKS_PER_BIT    (CPB),
    .FIFO_DEPTH_LOG2 (LOG2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sending   (sending),
    .packetIn  (packetIn),
    .full      (full),
    .overflow  (overflow),
    .fifoCount (fifoCount),
    .txOut     (txOut),
    .txBusy    (txBusy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard and frame monitor
  logic [7:0]  exp_q[$];
  int          starts[$];
  logic [10:0] mon_bits, last_bits;
  logic [7:0]  exp_byte;
  bit          mon_active = 0;
  bit          mon_glitch;
  int          mon_cnt, mon_k, frames_done = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_active = 0;
      end else begin
        if (!mon_active && txOut == 1'b0) begin
          mon_active = 1;
          mon_cnt    = 0;
          mon_glitch = 0;
          mon_bits   = '0;
          starts.push_back(cyc);
        end
        if (mon_active) begin
          mon_k = mon_cnt / CPB;
          if (mon_cnt % CPB == 0) mon_bits[mon_k] = txOut;
          else if (txOut !== mon_bits[mon_k]) mon_glitch = 1;
          if (mon_cnt == FRAME - 1) begin
            mon_active = 0;
            last_bits  = mon_bits;
            frames_done++;
            check_eq("start_bit", 32'(mon_bits[0]), 32'd0);
            check_eq("stop_bit", 32'(mon_bits[NBITS-1]), 32'd1);
            check_eq("bit_stable", 32'(mon_glitch), 32'd0);
            check_eq("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              exp_byte = exp_q.pop_front();
              check_eq("frame_data", 32'(mon_bits[8:1]), 32'(exp_byte));
`ifdef LINK_PARITY_EN
              check_eq("frame_parity", 32'(mon_bits[9]), 32'(^exp_byte));
`endif
            end
          end else begin
            mon_cnt++;
          end
        end
      end
    end
  end

  task automatic strobe(input logic [7:0] b, input bit accept);
    @(negedge clk);
    sending  = 1'b1;
    packetIn = b;
    if (accept) exp_q.push_back(b);
  endtask

  task automatic release_strobe();
    @(negedge clk);
    sending = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int fall);
    int n = 0;
    while (txBusy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_in_budget", 32'(n < budget), 32'd1);
    fall = cyc;
  endtask

  int strobe_cyc, fall_cyc, n_wait;
  logic [10:0] patt;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    sending  = 1'b0;
    packetIn = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_txOut", 32'(txOut), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_fifoCount", 32'(fifoCount), 32'd0);
    check_eq("rst_txBusy", 32'(txBusy), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5
    starts.delete();
    strobe(8'hA5, 1);
    release_strobe();
    strobe_cyc = cyc;
    check_eq("single_count", 32'(fifoCount), 32'd1);
    check_eq("single_busy", 32'(txBusy), 32'd1);
    wait_idle(200, fall_cyc);
    check_eq("single_nstarts", 32'(starts.size()), 32'd1);
    if (starts.size() >= 1) begin
      check_eq("single_latency", 32'(starts[0] - strobe_cyc), 32'd1);
      check_eq("single_busy_len", 32'(fall_cyc - starts[0]), 32'(FRAME));
    end
`ifdef LINK_PARITY_EN
    patt = 11'b1_0_10100101_0;
`else
    patt = 11'b0_1_10100101_0;
`endif
    check_eq("single_pattern", 32'(last_bits[NBITS-1:0]), 32'(patt[NBITS-1:0]));

    // Back-to-back 0x00, 0xFF
    repeat (3) @(negedge clk);
    starts.delete();
    strobe(8'h00, 1);
    strobe(8'hFF, 1);
    release_strobe();
    wait_idle(400, fall_cyc);
    check_eq("b2b_nstarts", 32'(starts.size()), 32'd2);
    if (starts.size() >= 2) begin
      check_eq("b2b_gap", 32'(starts[1] - starts[0]), 32'(FRAME));
      check_eq("b2b_total", 32'(fall_cyc - starts[0]), 32'(2 * FRAME));
    end

    // Overflow: 18 strobes, 17 accepted
    repeat (3) @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      strobe(8'(i), i < 17);
      if (i == 17) begin
        check_eq("ovf_count_pre", 32'(fifoCount), 32'd16);
        check_eq("ovf_full_pre", 32'(full), 32'd1);
        check_eq("ovf_flag_pre", 32'(overflow), 32'd0);
      end
    end
    release_strobe();
    check_eq("ovf_count", 32'(fifoCount), 32'd16);
    check_eq("ovf_full", 32'(full), 32'd1);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    wait_idle(17 * FRAME + 100, fall_cyc);
    check_eq("ovf_sticky", 32'(overflow), 32'd1);
    check_eq("ovf_full_drain", 32'(full), 32'd0);
    check_eq("ovf_sb_drained", 32'(exp_q.size()), 32'd0);

`ifdef LINK_PARITY_EN
    // Parity bit values
    repeat (3) @(negedge clk);
    starts.delete();
    strobe(8'h07, 1);
    release_strobe();
    wait_idle(200, fall_cyc);
    check_eq("par07_bit", 32'(last_bits[9]), 32'd1);
    if (starts.size() >= 1) check_eq("par07_len", 32'(fall_cyc - starts[0]), 32'd44);
    repeat (3) @(negedge clk);
    strobe(8'h03, 1);
    release_strobe();
    wait_idle(200, fall_cyc);
    check_eq("par03_bit", 32'(last_bits[9]), 32'd0);
`endif

    // Reset mid-frame with bytes queued
    repeat (3) @(negedge clk);
    starts.delete();
    strobe(8'h00, 0);
    strobe(8'h00, 0);
    strobe(8'h00, 0);
    release_strobe();
    n_wait = 0;
    while (starts.size() == 0 && n_wait < 20) begin
      @(negedge clk);
      n_wait++;
    end
    check_eq("rstmid_started", 32'(starts.size()), 32'd1);
    while (cyc - ((starts.size() != 0) ? starts[0] : cyc) < 9 && n_wait < 40) begin
      @(negedge clk);
      n_wait++;
    end
    check_eq("rstmid_line_low", 32'(txOut), 32'd0);
    check_eq("rstmid_queued", 32'(fifoCount), 32'd2);
    #1 reset = 1'b0;
    #1;
    check_eq("rstmid_txOut", 32'(txOut), 32'd1);
    check_eq("rstmid_count", 32'(fifoCount), 32'd0);
    check_eq("rstmid_overflow", 32'(overflow), 32'd0);
    check_eq("rstmid_busy", 32'(txBusy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    starts.delete();
    repeat (60) @(negedge clk);
    check_eq("rstmid_no_frame", 32'(starts.size()), 32'd0);
    check_eq("rstmid_idle_line", 32'(txOut), 32'd1);
    check_eq("rstmid_idle_busy", 32'(txBusy), 32'd0);
    check_eq("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
